adder_writeback: RTL and testbench

Downstream companion of the adder unit: tracks every operation issued into the fixed-latency adder pipeline, captures the adder result when it emerges tagged with its destination register, and buffers it in a small FIFO. The FIFO drains to the register-bank write port under a valid/ready handshake. Credit-based issue throttling guarantees that no result leaving the adder is ever lost, even when writeback stalls.

---
 rtl/my_pkg.sv | 14 +
 rtl/wb_fifo.sv | 83 ++++++++
 rtl/adder_writeback.sv | 99 +++++++++
 tb/tb_adder_writeback.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/my_pkg.sv
// Shared types and constants for the adder writeback path.
package my_pkg;

  localparam int unsigned WB_TAG_W  = 5;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned X0_IDX    = 0;

  // One buffered writeback: destination register plus result.
  typedef struct packed {
    logic [WB_TAG_W-1:0]  rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries with a registered head output.
module wb_fifo
  import my_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output wb_entry_t              head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             head_valid_q;
  wb_entry_t        head_q;

  logic             push_en;
  logic             pop_en;
  logic [CNT_W-1:0] count_next;
  logic [PTR_W-1:0] rd_ptr_next;
  wb_entry_t        head_next;

  // Qualify requests and compute the post-edge head entry.
  always_comb begin
    push_en     = push && (count_q != CNT_W'(DEPTH));
    pop_en      = pop && (count_q != '0);
    count_next  = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    rd_ptr_next = rd_ptr + PTR_W'(pop_en);
    head_next   = head_q;
    if (push_en && ((count_q - CNT_W'(pop_en)) == '0)) begin
      // New entry lands directly at the head (empty, or last one popping).
      head_next = push_entry;
    end else if (count_next != '0) begin
      head_next = mem[rd_ptr_next];
    end
  end

  // Storage array; contents need no reset since validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      wr_ptr       <= wr_ptr + PTR_W'(push_en);
      rd_ptr       <= rd_ptr_next;
      count_q      <= count_next;
      head_valid_q <= (count_next != '0);
      head_q       <= head_next;
    end
  end

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign head_valid = head_valid_q;
  assign head       = head_q;

  // Credit throttling upstream must make overflow impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/adder_writeback.sv
// Tracks ops through the adder pipeline, buffers tagged results, drains to the register bank.
module adder_writeback
  import my_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [TAG_W-1:0] issue_rd,
  output logic             issue_ready,
  input  logic             kill,
  input  logic [31:0]      adder_result,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_rd,
  output logic [31:0]      wb_data,
  input  logic             wb_ready,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned INF_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = ((INF_W > CNT_W) ? INF_W : CNT_W) + 1;

  logic [DEPTH-1:0] tag_v;
  logic [TAG_W-1:0] tag_rd [DEPTH];

  logic             issue_fire;
  logic             cap_push;
  wb_entry_t        cap_entry;
  logic [INF_W-1:0] inflight;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_head_valid;
  wb_entry_t        fifo_head;

  assign issue_fire = issue_valid && issue_ready;

  // Tag shift register, stage-aligned with the adder result registers; kill squashes every stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_rd[i] <= '0;
      end
    end else begin
      tag_v[0]  <= issue_fire && !kill;
      tag_rd[0] <= issue_rd;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        tag_v[i]  <= tag_v[i-1] && !kill;
        tag_rd[i] <= tag_rd[i-1];
      end
    end
  end

  // Capture the emerging result unless squashed or destined for x0.
  always_comb begin
    cap_push       = tag_v[DEPTH-1] && !kill && (tag_rd[DEPTH-1] != TAG_W'(X0_IDX));
    cap_entry.rd   = WB_TAG_W'(tag_rd[DEPTH-1]);
    cap_entry.data = WB_DATA_W'(adder_result);
  end

  // Count live tag stages for credit accounting.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      inflight = inflight + INF_W'(tag_v[i]);
    end
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (cap_push),
    .push_entry (cap_entry),
    .pop        (wb_ready),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head_valid (fifo_head_valid),
    .head       (fifo_head)
  );

  // Every in-flight op holds a reserved buffer slot, so a capture always has room.
  assign issue_ready = !fifo_full &&
                       ((SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH));

  assign busy     = (inflight != '0) || !fifo_empty;
  assign wb_valid = fifo_head_valid;
  assign wb_rd    = TAG_W'(fifo_head.rd);
  assign wb_data  = fifo_head.data;

endmodule

// File: tb/tb_adder_writeback.sv
// Directed self-checking bench for adder_writeback.
module tb_adder_writeback;

  localparam int unsigned DEPTH = 3;
  localparam int unsigned TAG_W = 5;

  logic             clk;
  logic             reset;
  logic             issue_valid;
  logic [TAG_W-1:0] issue_rd;
  logic             issue_ready;
  logic             kill;
  logic [31:0]      adder_result;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_rd;
  logic [31:0]      wb_data;
  logic             wb_ready;
  logic             busy;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] pipe [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  adder_writeback #(.DEPTH(DEPTH), .FIFO_DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .kill         (kill),
    .adder_result (adder_result),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Fixed-latency adder stand-in: samples operands every edge.
  always @(posedge clk) begin
    pipe[0] <= op_a + op_b;
    for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
  end
  assign adder_result = pipe[DEPTH-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; issue_valid = 1'b0; issue_rd = '0; kill = 1'b0; wb_ready = 1'b0;
    op_a = '0; op_b = '0;
    step(); step();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid: got %b, expected 0", wb_valid); end
    reset = 1'b0;
    step();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", wb_valid); end
    n_checks++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d, expected 0", wb_rd); end
    n_checks++; if (wb_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %0h, expected 0", wb_data); end
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1", issue_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_single();
    wb_ready = 1'b0; issue_valid = 1'b1; issue_rd = 5'd3; op_a = 32'd3; op_b = 32'd4;
    step();  // edge 0
    issue_valid = 1'b0; op_a = '0; op_b = '0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b, expected 1", busy); end
    step(); step();  // edge 2
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b, expected 0", wb_valid); end
    step();  // edge 3
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b, expected 1", wb_valid); end
    n_checks++; if (wb_rd !== 5'd3) begin n_fail++; $display("FAIL single_rd: got %0d, expected 3", wb_rd); end
    n_checks++; if (wb_data !== 32'd7) begin n_fail++; $display("FAIL single_data: got %0h, expected 7", wb_data); end
    wb_ready = 1'b1;
    step();  // edge 4: popped
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_popped: got %b, expected 0", wb_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b, expected 0", busy); end
    wb_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        issue_valid = 1'b1; issue_rd = 5'(c + 1); op_a = 32'(10 * (c + 1)); op_b = 32'(c + 1);
      end else begin
        issue_valid = 1'b0; op_a = '0; op_b = '0;
      end
      step();  // edge c
      if (c >= 3 && c <= 6) begin
        n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'(c - 2) || wb_data !== 32'(11 * (c - 2)))
          begin n_fail++; $display("FAIL b2b_wb%0d: got v=%b rd=%0d data=%0d, expected v=1 rd=%0d data=%0d",
                                   c - 2, wb_valid, wb_rd, wb_data, c - 2, 11 * (c - 2)); end
      end
      if (c == 3) begin
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_credit_full: got %b, expected 0", issue_ready); end
      end
      if (c == 4) begin
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_credit_back: got %b, expected 1", issue_ready); end
      end
    end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b, expected 0", wb_valid); end
    wb_ready = 1'b0;
  endtask

  task automatic test_stall_credit();
    int acc = 0;
    wb_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      issue_valid = 1'b1; issue_rd = 5'(6 + c); op_a = 32'(c + 1); op_b = 32'd100;
      if (issue_ready) acc++;
      step();
      if (c == 3) begin
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_drop: got %b, expected 0", issue_ready); end
      end
    end
    issue_valid = 1'b0; op_a = '0; op_b = '0;
    n_checks++; if (acc != 4) begin n_fail++; $display("FAIL stall_accepted: got %0d, expected 4", acc); end
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b, expected 0", issue_ready); end
    n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd6 || wb_data !== 32'd101)
      begin n_fail++; $display("FAIL stall_head_stable: got v=%b rd=%0d data=%0d, expected v=1 rd=6 data=101", wb_valid, wb_rd, wb_data); end
    wb_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'(6 + j) || wb_data !== 32'(101 + j))
        begin n_fail++; $display("FAIL stall_drain%0d: got v=%b rd=%0d data=%0d, expected v=1 rd=%0d data=%0d",
                                 j, wb_valid, wb_rd, wb_data, 6 + j, 101 + j); end
      step();
      if (j == 0) begin
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_return: got %b, expected 1", issue_ready); end
      end
    end
    n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got v=%b busy=%b, expected 0 0", wb_valid, busy); end
    wb_ready = 1'b0;
  endtask

  task automatic test_x0_discard();
    logic [4:0] rds [8] = '{5'd0, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
    logic [4:0] exp_rd [4] = '{5'd5, 5'd6, 5'd7, 5'd8};
    int acc = 0;
    wb_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      issue_valid = 1'b1; issue_rd = rds[c]; op_a = 32'(rds[c]); op_b = 32'h100;
      if (issue_ready) acc++;
      step();
      if (c == 3) begin
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL x0_credit_return: got %b, expected 1", issue_ready); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL x0_no_push: got %b, expected 0", wb_valid); end
      end
      if (c == 4) begin
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL x0_ready_drop: got %b, expected 0", issue_ready); end
      end
    end
    issue_valid = 1'b0; op_a = '0; op_b = '0;
    n_checks++; if (acc != 5) begin n_fail++; $display("FAIL x0_accepted: got %0d, expected 5", acc); end
    wb_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (wb_valid !== 1'b1 || wb_rd !== exp_rd[j] || wb_data !== (32'h100 + 32'(exp_rd[j])))
        begin n_fail++; $display("FAIL x0_drain%0d: got v=%b rd=%0d data=%0h, expected v=1 rd=%0d data=%0h",
                                 j, wb_valid, wb_rd, wb_data, exp_rd[j], 32'h100 + 32'(exp_rd[j])); end
      step();
    end
    n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL x0_empty: got v=%b busy=%b, expected 0 0", wb_valid, busy); end
    wb_ready = 1'b0;
  endtask

  task automatic test_kill();
    wb_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      issue_valid = (c == 0) || (c >= 3 && c <= 5);
      issue_rd    = (c == 0) ? 5'd12 : 5'(10 + c);
      op_a        = (c == 0) ? 32'h12 : 32'(10 + c);
      op_b        = '0;
      kill        = (c == 6);
      step();
      if (c == 5) begin
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL kill_pre_ready: got %b, expected 0", issue_ready); end
      end
    end
    kill = 1'b0; issue_valid = 1'b0; op_a = '0;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL kill_credit: got %b, expected 1", issue_ready); end
    n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd12 || wb_data !== 32'h12)
      begin n_fail++; $display("FAIL kill_buffered: got v=%b rd=%0d data=%0h, expected v=1 rd=12 data=12", wb_valid, wb_rd, wb_data); end
    step(); step(); step();
    n_checks++; if (wb_rd !== 5'd12 || busy !== 1'b1) begin n_fail++; $display("FAIL kill_no_push: got rd=%0d busy=%b, expected rd=12 busy=1", wb_rd, busy); end
    wb_ready = 1'b1;
    step();
    n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL kill_drained: got v=%b busy=%b, expected 0 0", wb_valid, busy); end
    // Kill on the same edge as an accepted issue squashes that issue too.
    issue_valid = 1'b1; issue_rd = 5'd17; kill = 1'b1;
    step();
    issue_valid = 1'b0; kill = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_same_edge: got busy=%b, expected 0", busy); end
    wb_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    wb_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      issue_valid = (c == 0) || (c == 1) || (c == 3);
      issue_rd    = 5'(20 + c);
      op_a        = 32'(c + 1); op_b = '0;
      step();
    end
    issue_valid = 1'b0;
    n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd20 || busy !== 1'b1)
      begin n_fail++; $display("FAIL rmid_pre: got v=%b rd=%0d busy=%b, expected v=1 rd=20 busy=1", wb_valid, wb_rd, busy); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b, expected 0", wb_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b, expected 0", busy); end
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b, expected 1", issue_ready); end
    #2 reset = 1'b0;
    wb_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (wb_valid) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rmid_no_wb: got %0d writebacks, expected 0", seen); end
    wb_ready = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall_credit();
    test_x0_discard();
    test_kill();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
